// File: rtl/step_pkg.sv
// Shared definitions for the stepper command sequencer: default widths,
// default hold time, state encoding and the hold-counter width helper.
package step_pkg;

    localparam int unsigned STEP_W_DEF      = 16;
    localparam int unsigned PER_W_DEF       = 20;
    localparam int unsigned HOLD_CYCLES_DEF = 50000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Bits needed to hold a count of 0..cycles.
    function automatic int unsigned hold_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter with a zero flag.
// Ports: clk, rst_n (async active-low), load/load_val (load has priority),
//        dec (count down, saturating at zero), zero_c (count == 0, combinational).
module step_timer
    import step_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero_c) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/step_sequencer.sv
// Command stage for the four-phase stepper driver: accepts move commands
// over valid/ready, steps the 3-bit phase counter at the commanded period,
// then keeps the coils energized for HOLD_CYCLES before releasing them.
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready handshake with
//        cmd_dir, cmd_steps, cmd_period; stop (level abort);
//        enable, dir, cnt8 to the driver; busy, done, steps_left status.
//        All outputs registered except cmd_ready.
module step_sequencer
    import step_pkg::*;
#(
    parameter int unsigned STEP_W      = STEP_W_DEF,
    parameter int unsigned PER_W       = PER_W_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [PER_W-1:0]  cmd_period,
    input  logic              stop,
    output logic              enable,
    output logic              dir,
    output logic [2:0]        cnt8,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left
);

    localparam int unsigned HOLD_W = hold_w(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state;
    state_t              state_nx;
    logic [PER_W-1:0]    per_rld;
    logic [PER_W-1:0]    per_rld_nx;
    logic [PER_W-1:0]    cmd_per_m1;
    logic                enable_nx;
    logic                dir_nx;
    logic [2:0]          cnt8_nx;
    logic                busy_nx;
    logic                done_nx;
    logic [STEP_W-1:0]   steps_left_nx;
    logic                accept;
    logic                step_due;
    logic                run_end;
    logic                per_zero;
    logic                hold_zero;

    assign cmd_ready  = ((state == ST_IDLE) || (state == ST_HOLD)) && !stop;
    assign accept     = cmd_valid && cmd_ready;
    // A zero period behaves as one step per clock.
    assign cmd_per_m1 = (cmd_period == '0) ? '0 : cmd_period - PER_W'(1);
    assign step_due   = (state == ST_RUN) && per_zero;
    // Leaving RUN: either an abort or the step that exhausts the count.
    assign run_end    = (state == ST_RUN) &&
                        (stop || (step_due && (steps_left == STEP_W'(1))));

    // Period timer: loaded at accept and reloaded on every step.
    step_timer #(.W(PER_W)) u_per_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept || step_due),
        .load_val (accept ? cmd_per_m1 : per_rld),
        .dec      (state == ST_RUN),
        .zero_c   (per_zero)
    );

    // Hold timer: armed when motion ends, counts only while in HOLD.
    step_timer #(.W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (run_end),
        .load_val (HOLD_LOAD),
        .dec      (state == ST_HOLD),
        .zero_c   (hold_zero)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            per_rld    <= '0;
            enable     <= 1'b0;
            dir        <= 1'b0;
            cnt8       <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
        end else begin
            state      <= state_nx;
            per_rld    <= per_rld_nx;
            enable     <= enable_nx;
            dir        <= dir_nx;
            cnt8       <= cnt8_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            steps_left <= steps_left_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept && (cmd_steps != '0)) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (run_end) state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept && (cmd_steps != '0)) state_nx = ST_RUN;
                else if (stop || hold_zero)      state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        dir_nx        = dir;
        cnt8_nx       = cnt8;
        steps_left_nx = steps_left;
        per_rld_nx    = per_rld;
        done_nx       = 1'b0;
        if (accept) begin
            dir_nx        = cmd_dir;
            steps_left_nx = cmd_steps;
            per_rld_nx    = cmd_per_m1;
            done_nx       = (cmd_steps == '0);
        end
        // A step due in the same cycle as stop is still taken.
        if (step_due) begin
            cnt8_nx       = cnt8 + 3'd1;
            steps_left_nx = steps_left - STEP_W'(1);
        end
        if (run_end) begin
            steps_left_nx = '0;
            done_nx       = 1'b1;
        end
        enable_nx = (state_nx != ST_IDLE);
        busy_nx   = (state_nx == ST_RUN);
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios with literal expectations,
// then random commands/stops, all checked each cycle against a timeline model.
module tb_step_sequencer;

    localparam int unsigned STEP_W = 16;
    localparam int unsigned PER_W  = 20;
    localparam int unsigned HOLD   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_dir = 1'b0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [PER_W-1:0]  cmd_period = '0;
    logic              stop = 1'b0;
    logic              enable;
    logic              dir;
    logic [2:0]        cnt8;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    step_sequencer #(
        .STEP_W      (STEP_W),
        .PER_W       (PER_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .stop       (stop),
        .enable     (enable),
        .dir        (dir),
        .cnt8       (cnt8),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: moves tracked as absolute edge numbers of the next
    // step and of the end of the hold window.
    int cyc = 0;
    bit m_run = 0, m_hold = 0, m_dir = 0, m_done = 0;
    int m_cnt = 0, m_left = 0, m_per = 1, m_next = 0, m_hend = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 0; m_hold = 0; m_dir = 0; m_done = 0;
                m_cnt = 0; m_left = 0;
            end else begin
                cyc++;
                m_done = 0;
                if (m_run) begin
                    if (cyc == m_next) begin
                        m_cnt  = (m_cnt + 1) % 8;
                        m_left = m_left - 1;
                        m_next = cyc + m_per;
                    end
                    if (stop || m_left == 0) begin
                        m_run = 0; m_hold = 1; m_hend = cyc + HOLD;
                        m_left = 0; m_done = 1;
                    end
                end else begin
                    if (cmd_valid && !stop) begin
                        m_dir  = cmd_dir;
                        m_left = int'(cmd_steps);
                        m_per  = (cmd_period == '0) ? 1 : int'(cmd_period);
                        if (cmd_steps == '0) m_done = 1;
                        else begin
                            m_run = 1; m_hold = 0; m_next = cyc + m_per;
                        end
                    end
                    if (m_hold && (stop || cyc == m_hend)) m_hold = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("enable",     32'(enable),     32'(m_run || m_hold));
            check("busy",       32'(busy),       32'(m_run));
            check("dir",        32'(dir),        32'(m_dir));
            check("cnt8",       32'(cnt8),       32'(m_cnt));
            check("done",       32'(done),       32'(m_done));
            check("steps_left", 32'(steps_left), 32'(m_left));
            check("cmd_ready",  32'(cmd_ready),  32'(!m_run && !stop));
        end
    end

    task automatic skip(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int acc_cyc = 0;

    // Offer a command and return #1 after the accepting edge.
    task automatic send_cmd(input logic d, input int steps, input int per);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = STEP_W'(steps);
        cmd_period = PER_W'(per);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                acc_cyc   = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: command not accepted within 500 cycles at %0t", $time);
        cmd_valid = 1'b0;
    endtask

    int c0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", 32'(enable), 0);
        check("rst_cnt8", 32'(cnt8), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_steps_left", 32'(steps_left), 0);
        check("rst_dir", 32'(dir), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        skip(2);

        // Basic move: 5 steps, period 4.
        send_cmd(1'b1, 5, 4);
        check("t1_dir", 32'(dir), 1);
        check("t1_busy", 32'(busy), 1);
        skip(3);  check("t1_pre_step", 32'(cnt8), 0);
        skip(1);  check("t1_step1", 32'(cnt8), 1);
        skip(16); check("t1_step5", 32'(cnt8), 5);
        check("t1_done", 32'(done), 1);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_model_cnt", 32'(m_cnt), 5);
        skip(7);  check("t1_hold_last", 32'(enable), 1);
        skip(1);  check("t1_release", 32'(enable), 0);

        // Phase wrap at period 1.
        send_cmd(1'b1, 4, 1);
        check("t2_busy0", 32'(busy), 1);
        skip(1); check("t2_c6", 32'(cnt8), 6); check("t2_busy1", 32'(busy), 1);
        skip(1); check("t2_c7", 32'(cnt8), 7);
        skip(1); check("t2_c0", 32'(cnt8), 0); check("t2_busy3", 32'(busy), 1);
        skip(1); check("t2_c1", 32'(cnt8), 1); check("t2_done", 32'(done), 1);

        // New command three clocks into HOLD.
        skip(2);
        send_cmd(1'b0, 2, 2);
        check("t3_dir", 32'(dir), 0);
        check("t3_enable", 32'(enable), 1);
        skip(2); check("t3_c2", 32'(cnt8), 2);
        skip(2); check("t3_c3", 32'(cnt8), 3); check("t3_done", 32'(done), 1);

        // Abort with 3 of 10 steps remaining.
        send_cmd(1'b1, 10, 4);
        skip(28); check("t4_left3", 32'(steps_left), 3); check("t4_cnt", 32'(cnt8), 2);
        skip(1);  stop = 1'b1;
        skip(1);
        check("t4_left0", 32'(steps_left), 0);
        check("t4_done", 32'(done), 1);
        check("t4_cnt_held", 32'(cnt8), 2);
        check("t4_hold_en", 32'(enable), 1);
        skip(1);
        check("t4_release", 32'(enable), 0);
        check("t4_no_done", 32'(done), 0);
        stop = 1'b0;
        skip(4); check("t4_cnt_final", 32'(cnt8), 2);

        // Zero steps, then zero period.
        send_cmd(1'b0, 0, 5);
        check("t5_done", 32'(done), 1);
        check("t5_enable", 32'(enable), 0);
        check("t5_cnt", 32'(cnt8), 2);
        skip(1); check("t5_done_clr", 32'(done), 0);
        send_cmd(1'b1, 3, 0);
        skip(1); check("t5_p0_c3", 32'(cnt8), 3);
        skip(1); check("t5_p0_c4", 32'(cnt8), 4);
        skip(1); check("t5_p0_c5", 32'(cnt8), 5); check("t5_p0_done", 32'(done), 1);

        // Handshake while running, stop with valid, async reset.
        skip(10);
        send_cmd(1'b1, 6, 3);
        c0 = acc_cyc;
        skip(1); check("t6_ready_run", 32'(cmd_ready), 0);
        send_cmd(1'b0, 2, 1);
        check("t6_accept_delay", 32'(acc_cyc - c0), 19);
        skip(2);
        cmd_valid = 1'b1; cmd_steps = STEP_W'(3); stop = 1'b1;
        #1; check("t6_ready_stop", 32'(cmd_ready), 0);
        skip(1);
        check("t6_stop_idle", 32'(enable), 0);
        check("t6_not_taken", 32'(busy), 0);
        cmd_valid = 1'b0; stop = 1'b0;
        send_cmd(1'b1, 20, 2);
        skip(5);
        #2; rst_n = 1'b0;
        #1;
        check("t6_arst_enable", 32'(enable), 0);
        check("t6_arst_cnt8", 32'(cnt8), 0);
        check("t6_arst_busy", 32'(busy), 0);
        check("t6_arst_left", 32'(steps_left), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        skip(1);

        // Random traffic.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                send_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                         int'($urandom_range(0, 4)));
            end else if (r <= 7) begin
                skip(int'($urandom_range(1, 12)));
            end else begin
                stop = 1'b1;
                skip(int'($urandom_range(1, 2)));
                stop = 1'b0;
            end
        end
        skip(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Upstream command stage for the four-phase stepper coil driver.
- Accepts move commands (direction, step count, step period) from the IR command decoder over a valid/ready handshake.
- Produces the driver's enable, dir and 3-bit phase count (cnt8) at the commanded step rate.
- Holds the coils energized for a programmable time after motion, then releases them.

Parameters:
STEP_W, 16, width of step count and remaining-steps counter
PER_W, 20, width of step period (clocks per step)
HOLD_CYCLES, 50000, clocks coils stay energized after last step (1 ms at 50 MHz); must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_dir  in  1  direction, passed to driver dir
cmd_steps  in  STEP_W  number of steps to execute
cmd_period  in  PER_W  clocks between steps; 0 treated as 1
stop  in  1  abort request, level-sensitive
enable  out  1  driver enable (coils energized)
dir  out  1  latched direction
cnt8  out  3  phase counter to driver
busy  out  1  1 in RUN
done  out  1  one-cycle pulse: move finished or aborted
steps_left  out  STEP_W  remaining steps

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs are registered except cmd_ready.
- Reset values: enable=0, dir=0, cnt8=0, busy=0, done=0, steps_left=0; state=IDLE.
- cmd_ready = (state==IDLE or HOLD) & ~stop. This is combinational.
- States: IDLE, RUN, HOLD.
- IDLE: enable=0. cnt8 is retained; it is not reset between moves.
- Accept, from IDLE or HOLD:
  - Latch dir=cmd_dir, steps_left=cmd_steps, per_cnt=max(cmd_period,1)-1.
  - If cmd_steps==0: no motion, state unchanged, done=1 next cycle.
  - Otherwise: next state RUN, enable=1 and busy=1 from the next cycle.
- RUN:
  - per_cnt decrements each clock.
  - When per_cnt==0: cnt8<=cnt8+1 (mod 8, 7->0 wraps), steps_left-1, per_cnt reloaded with period-1.
  - First step lands exactly P clocks after the accept edge; steps are spaced P clocks apart.
  - On the step that makes steps_left 0: enter HOLD, done=1 in that same cycle, busy=0.
- cnt8 always increments. Direction reversal is done by the driver's coil remapping via dir, not by this block.
- HOLD:
  - enable=1; hold counter runs HOLD_CYCLES clocks, then state IDLE and enable=0.
  - A command accepted in HOLD goes straight to RUN; enable stays 1 with no glitch, and the hold counter is discarded.
- stop:
  - In RUN: remaining steps are cancelled and steps_left=0. State goes to HOLD with done=1 next cycle.
  - If stop coincides with a due step, that step is still taken (cnt8 increments) and done pulses once only.
  - In HOLD: immediate IDLE, enable=0 next cycle, no done.
  - In IDLE: no effect.
- cmd_valid held while cmd_ready=0: the command is not consumed, and the upstream must hold it.
- Reset asserted mid-move: all outputs go to reset values immediately and asynchronously; the in-progress move is lost.
- Latency to the coils: the driver registers once more, so coil outputs follow cnt8 by 1 clock.

Decomposition:
- Shared package step_pkg:
  - State encoding constants: ST_IDLE, ST_RUN, ST_HOLD.
  - Default widths STEP_W and PER_W.
  - HOLD_CYCLES default.
  - Counter width function clog2(HOLD_CYCLES+1).
- One natural sub-module: step_timer, a loadable down-counter with zero flag. It is instantiated twice, once for the period and once for the hold time.

Test Plan (bench uses HOLD_CYCLES=8):
1. Reset, then cmd dir=1 steps=5 period=4:
   - cnt8 goes 0→1→2→3→4→5 at accept+4, +8, +12, +16, +20.
   - done pulses with the 5th step.
   - enable stays 1 for 8 more clocks, then drops to 0.
2. Wrap: start with cnt8=5, steps=4, period=1:
   - cnt8 sequence is 6,7,0,1 on consecutive clocks.
   - busy is 1 throughout the 4 clocks.
3. Command in HOLD: a 2nd cmd (dir=0, steps=2) accepted 3 clocks into HOLD:
   - enable never drops.
   - dir goes to 0 the next clock.
   - Exactly 2 further increments occur.
4. stop asserted at remaining step 3 of 10, period=4:
   - No further cnt8 change.
   - steps_left=0, one done pulse, HOLD entered.
   - stop held 1 clock in HOLD gives enable=0 next clock.
5. Degenerate commands:
   - steps=0 gives done 1 clock after accept, enable stays 0, cnt8 unchanged.
   - period=0 with steps=3 steps on 3 consecutive clocks.
6. Handshake and reset:
   - cmd_valid during RUN is not accepted until HOLD; stop with cmd_valid in the same cycle leaves cmd_ready=0.
   - rst_n pulled low mid-RUN forces enable, cnt8 and busy to 0 asynchronously.
